// File: rtl/move_input_conditioner.sv
// Turns four raw direction buttons into one registered, priority-resolved
// move per physical press, offered to the game FSM over valid/ready.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       move_ready,
  output logic       move_valid,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [7:0] move_count
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PENDING, HELD} state_t;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] cand_q;
  logic [3:0] dir_q;
  logic [7:0] cnt_q;
  logic [7:0] rcnt_q;
  logic [7:0] count_q;
  logic       valid_q;

  // Vector ordering is {U, D, L, R}; up wins, right loses.
  function automatic logic [3:0] prio(input logic [3:0] c);
    if (c[3])      return 4'b1000;
    else if (c[2]) return 4'b0100;
    else if (c[1]) return 4'b0010;
    else if (c[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  // NOTE: non-blocking assignments make each flop sample the pre-edge value
  // of its neighbour, so the chain really is two stages deep.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {BtnU, BtnD, BtnL, BtnR};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      dir_q   <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sync2_q != 4'b0000) begin
            cand_q  <= sync2_q;
            cnt_q   <= '0;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sync2_q != cand_q) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == LAST) begin
            dir_q   <= prio(cand_q);
            valid_q <= 1'b1;
            state_q <= PENDING;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PENDING: begin
          // Button activity is ignored here; only the handshake moves on.
          if (move_ready) begin
            count_q <= count_q + 8'd1;
            rcnt_q  <= '0;
            valid_q <= 1'b0;
            dir_q   <= '0;
            state_q <= HELD;
          end
        end
        HELD: begin
          if (sync2_q != 4'b0000) begin
            rcnt_q <= '0;
          end else if (rcnt_q == LAST) begin
            state_q <= IDLE;
          end else begin
            rcnt_q <= rcnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign move_valid = valid_q;
  assign up         = dir_q[3];
  assign down       = dir_q[2];
  assign left       = dir_q[1];
  assign right      = dir_q[0];
  assign move_count = count_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench: stimulus pushes expected moves into a scoreboard queue and a
// negedge monitor checks direction, timing and count of every presented move.
module tb_move_input_conditioner;

  localparam int D = 4;

  logic       Clk;
  logic       Reset;
  logic       BtnU, BtnD, BtnL, BtnR;
  logic       move_ready;
  logic       move_valid;
  logic       up, down, left, right;
  logic [7:0] move_count;

  move_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .BtnU       (BtnU),
    .BtnD       (BtnD),
    .BtnL       (BtnL),
    .BtnR       (BtnR),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .move_count (move_count)
  );

  typedef struct {
    logic [3:0] dir;
    logic [7:0] count;
    int         valid_edge;
    int         xfer_edge;
  } move_t;

  move_t      sb[$];
  move_t      cur;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] exp_moves = 8'd0;
  logic [7:0] exp_cnt   = 8'd0;
  logic       chk_count = 1'b0;
  logic       prev_valid = 1'b0;
  logic [3:0] dir_now;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Edge numbering: after rising edge n, cyc == n.
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Called right after an input change at cycle `cyc` (raw high before edge cyc+1).
  task automatic push_move(input logic [3:0] dir, input int valid_edge, input int xfer_edge);
    move_t m;
    exp_moves = exp_moves + 8'd1;
    m.dir        = dir;
    m.count      = exp_moves;
    m.valid_edge = valid_edge;
    m.xfer_edge  = xfer_edge;
    sb.push_back(m);
  endtask

  task automatic release_all(input int gap);
    {BtnU, BtnD, BtnL, BtnR} = 4'b0000;
    wait_cyc(gap);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    dir_now = {up, down, left, right};
    if (chk_count) begin
      check("count_after_xfer", {24'd0, move_count}, {24'd0, exp_cnt});
      check("valid_drop_after_xfer", {31'd0, move_valid}, 32'd0);
      chk_count = 1'b0;
    end
    if (move_valid) begin
      check("expected_move_present", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() != 0) begin
        cur = sb[0];
        if (!prev_valid) check("valid_edge", cyc, cur.valid_edge);
        check("dir", {28'd0, dir_now}, {28'd0, cur.dir});
        if (move_ready) begin
          check("xfer_edge", cyc + 1, cur.xfer_edge);
          exp_cnt   = cur.count;
          chk_count = 1'b1;
          void'(sb.pop_front());
        end
      end
    end else if (dir_now != 4'b0000) begin
      check("dir_zero_when_idle", {28'd0, dir_now}, 32'd0);
    end
    prev_valid = move_valid;
  end

  int n;

  initial begin
    Reset = 1'b1;
    {BtnU, BtnD, BtnL, BtnR} = 4'b0000;
    move_ready = 1'b0;
    wait_cyc(3);
    check("rst_valid", {31'd0, move_valid}, 32'd0);
    check("rst_dir", {28'd0, up, down, left, right}, 32'd0);
    check("rst_count", {24'd0, move_count}, 32'd0);
    Reset = 1'b0;
    wait_cyc(3);

    // Clean press of U; held 100 extra cycles must not repeat.
    move_ready = 1'b1;
    BtnU = 1'b1;
    n = cyc;
    push_move(4'b1000, n + D + 3, n + D + 4);
    wait_cyc(D + 5 + 100);
    release_all(D + 6);

    // Bounce on L: ten toggles ending high.
    for (int i = 0; i < 10; i++) begin
      BtnL = ~BtnL;
      wait_cyc(1);
    end
    BtnL = 1'b1;
    n = cyc;
    push_move(4'b0010, n + D + 3, n + D + 4);
    wait_cyc(D + 20);
    release_all(D + 6);

    // Simultaneous D and R: down wins.
    BtnD = 1'b1;
    BtnR = 1'b1;
    n = cyc;
    push_move(4'b0100, n + D + 3, n + D + 4);
    wait_cyc(D + 20);
    release_all(D + 6);

    // Backpressure: valid held 20 cycles, then ready raised.
    move_ready = 1'b0;
    BtnR = 1'b1;
    n = cyc;
    push_move(4'b0001, n + D + 3, n + D + 24);
    wait_cyc(D + 23);
    move_ready = 1'b1;
    wait_cyc(10);
    release_all(D + 6);

    // Release gap of D-1 cycles does not re-arm.
    BtnU = 1'b1;
    n = cyc;
    push_move(4'b1000, n + D + 3, n + D + 4);
    wait_cyc(D + 5);
    BtnU = 1'b0;
    wait_cyc(D - 1);
    BtnU = 1'b1;
    wait_cyc(30);
    release_all(D + 6);
    check("count_before_reset", {24'd0, move_count}, 32'd5);

    // Reset while pending with move_count == 5.
    move_ready = 1'b0;
    BtnL = 1'b1;
    n = cyc;
    push_move(4'b0010, n + D + 3, -1);
    wait_cyc(D + 8);
    check("pending_before_reset", {31'd0, move_valid}, 32'd1);
    #3;
    Reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, move_valid}, 32'd0);
    check("async_rst_dir", {28'd0, up, down, left, right}, 32'd0);
    check("async_rst_count", {24'd0, move_count}, 32'd0);
    void'(sb.pop_front());
    exp_moves = 8'd0;
    wait_cyc(2);
    Reset = 1'b0;
    move_ready = 1'b1;
    n = cyc;
    push_move(4'b0010, n + D + 3, n + D + 4);
    wait_cyc(D + 10);
    release_all(D + 6);

    // 256 press/release cycles: count wraps through 0 back to 1.
    for (int i = 0; i < 256; i++) begin
      BtnD = 1'b1;
      n = cyc;
      push_move(4'b0100, n + D + 3, n + D + 4);
      wait_cyc(D + 5);
      release_all(D + 2);
    end
    wait_cyc(10);
    check("count_after_wrap", {24'd0, move_count}, 32'd1);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_input_conditioner.md
# move_input_conditioner

Conditions the four raw direction buttons into clean, one-move-per-press commands for the 2048 game state machine. The block sits directly upstream of the game FSM and runs on the same slow move clock. Per button it provides 2-flop synchronisation, a stability debounce, and press-and-release lockout. It issues a single priority-resolved one-hot direction per physical press over a valid/ready handshake, and counts accepted moves.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a press and to accept a release (legal range 1-255).
- Clk  input  1  move clock (slow divided clock); all state on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- BtnU, BtnD, BtnL, BtnR  input  1 each  raw, asynchronous button levels.
- move_ready  input  1  consumer can accept a move this cycle (game FSM waiting).
- move_valid  output  1  a resolved move is pending.
- up, down, left, right  output  1 each  one-hot direction; nonzero only while move_valid=1.
- move_count  output  8  number of accepted moves, wrapping.

## Operation
- Synchroniser: two flops per button, reset 0. Synchronised vector s = {U,D,L,R}.
- FSM states and transitions:
  - IDLE: if s != 0, latch cand <= s, cnt <= 0, go to DEBOUNCE.
  - DEBOUNCE:
    - s != cand: go to IDLE, cnt <= 0.
    - s == cand and cnt == DEBOUNCE_CYCLES-1: latch dir <= priority(cand), go to PENDING.
    - s == cand otherwise: cnt <= cnt+1.
  - PENDING: move_valid=1 and the dir bit asserted as a level. When move_ready=1 on a rising edge the handshake completes: move_count <= move_count+1 (255 wraps to 0), rcnt <= 0, go to HELD. The direction holds indefinitely while move_ready=0; button activity in PENDING is ignored.
  - HELD:
    - s != 0: rcnt <= 0.
    - s == 0 and rcnt == DEBOUNCE_CYCLES-1: go to IDLE.
    - s == 0 otherwise: rcnt <= rcnt+1.
- Priority for multi-button cand: U > D > L > R. Outputs are always one-hot or zero.
- A held button produces exactly one move. A new move requires a full debounced release followed by a new debounced press.
- cnt and rcnt are 8 bits wide. Both are compared only against DEBOUNCE_CYCLES-1, so they never wrap.

## Timing
- Reset (asynchronous, any time, including mid-DEBOUNCE or PENDING): state=IDLE, sync flops=0, cnt=rcnt=0, move_valid=0, up=down=left=right=0, move_count=0. A pending move is discarded.
- Press latency: raw button high before edge k and stable afterwards gives:
  - sync1=1 at edge k, s=1 after edge k+1.
  - DEBOUNCE entered at edge k+2.
  - PENDING (move_valid=1) after edge k+2+DEBOUNCE_CYCLES.
- Handshake: a transfer occurs on a rising edge with move_valid=1 and move_ready=1. move_valid deasserts after that same edge. move_valid never asserts in the cycle after a transfer.
- move_ready high while not PENDING has no effect.
- Release latency: after the transfer, s must read 0 for DEBOUNCE_CYCLES consecutive edges before IDLE is re-entered.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, move_ready=1: BtnU high at edge 0 -> move_valid=1 with up=1 only after edge 6, low after edge 7, move_count=1; holding BtnU 100 more cycles gives no further move.
- Bounce: BtnL toggles every cycle for 10 cycles, then stays high -> no move_valid during toggling; left=1 exactly DEBOUNCE_CYCLES+2 edges after the last toggle, one move only.
- Simultaneous press: BtnD and BtnR rise together -> down=1, right=0, single move.
- Backpressure: press BtnR with move_ready=0 for 20 cycles, then raise it -> right=1 held steady for all 20 cycles; transfer on the first ready edge; move_count increments by exactly 1.
- Re-press and wrap: 256 press/release cycles with release gaps ≥ DEBOUNCE_CYCLES -> 256 transfers, move_count returns to 0. A release gap of DEBOUNCE_CYCLES-1 cycles yields no second move.
- Reset mid-operation: assert Reset while in PENDING with move_count=5 -> all outputs 0 immediately (asynchronous). After release with the button still held, a fresh move is produced after the full press latency.
